// File: rtl/logic_probe1.sv
// Logic-probe core: synchronizes window-comparator outputs, drives the threshold DAC code,
// and stretches level/transition indications for the LEDs. Define LOGIC_PROBE_PULSE_MEMORY_EN to latch led_pulse.
module logic_probe1 #(
    parameter int COUNTER_WIDTH = 20
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       comp_data_hi,
    input  logic       comp_data_lo,
    input  logic [1:0] mode,
    output logic [3:0] dac_value,
    output logic       led_one,
    output logic       led_zero,
    output logic       led_floating,
    output logic       led_pulse
);
    localparam int NCNT = 3;  // 0: one, 1: zero, 2: pulse
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

    logic [1:0] hi_sync, lo_sync;
    logic       hi_d, lo_d;
    logic       hi_s, lo_s;
    logic       lvl_one, lvl_zero, pulse_evt;

    logic [NCNT-1:0]                    load;
    logic [NCNT-1:0][COUNTER_WIDTH-1:0] cnt, cnt_next;

    assign hi_s      = hi_sync[1];
    assign lo_s      = lo_sync[1];
    assign lvl_one   = hi_s & ~lo_s;
    assign lvl_zero  = lo_s & ~hi_s;
    // Simultaneous hi/lo edges collapse into a single event.
    assign pulse_evt = (hi_s & ~hi_d) | (lo_s & ~lo_d);
    assign load      = {pulse_evt, lvl_zero, lvl_one};

    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NCNT; i++) begin
            if (load[i])
                cnt_next[i] = '1;
            else if (cnt[i] != '0)
                cnt_next[i] = cnt[i] - CNT_ONE;
            else
                cnt_next[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hi_sync <= '0;
            lo_sync <= '0;
            hi_d    <= 1'b0;
            lo_d    <= 1'b0;
            cnt     <= '0;
        end else begin
            hi_sync <= {hi_sync[0], comp_data_hi};
            lo_sync <= {lo_sync[0], comp_data_lo};
            hi_d    <= hi_s;
            lo_d    <= lo_s;
            cnt     <= cnt_next;
        end
    end

    // Level LEDs track the post-load count so they light on the same edge the counter loads;
    // the pulse LED follows the stored count and therefore lags by one cycle.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            dac_value <= 4'd0;
            led_one   <= 1'b0;
            led_zero  <= 1'b0;
            led_pulse <= 1'b0;
        end else begin
            case (mode)
                2'd0:    dac_value <= 4'd12;
                2'd1:    dac_value <= 4'd8;
                2'd2:    dac_value <= 4'd6;
                default: dac_value <= 4'd4;
            endcase
            led_one  <= (cnt_next[0] != '0);
            led_zero <= (cnt_next[1] != '0);
`ifdef LOGIC_PROBE_PULSE_MEMORY_EN
            led_pulse <= led_pulse | (cnt[2] != '0);
`else
            led_pulse <= (cnt[2] != '0);
`endif
        end
    end

    assign led_floating = ~led_one & ~led_zero;
endmodule

// File: tb/tb_logic_probe1.sv
// Scoreboard bench for logic_probe1: each test queues cycle-stamped expectations, then pops and checks them as the DUT runs.
module tb_logic_probe1;
    localparam int W     = 12;
    localparam int S     = (1 << W) - 1;
    localparam int LIMIT = 20000;
`ifdef LOGIC_PROBE_PULSE_MEMORY_EN
    localparam bit PMEM = 1'b1;
`else
    localparam bit PMEM = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       comp_data_hi = 1'b0;
    logic       comp_data_lo = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [3:0] dac_value;
    logic       led_one, led_zero, led_floating, led_pulse;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic [7:0] mask;
        logic [7:0] val;
        string      name;
    } exp_t;
    exp_t sb[$];

    logic_probe1 #(.COUNTER_WIDTH(W)) dut (
        .clk(clk), .nreset(nreset), .comp_data_hi(comp_data_hi), .comp_data_lo(comp_data_lo),
        .mode(mode), .dac_value(dac_value), .led_one(led_one), .led_zero(led_zero),
        .led_floating(led_floating), .led_pulse(led_pulse)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs_now();
        return {dac_value, led_one, led_zero, led_floating, led_pulse};
    endfunction

    function automatic logic [7:0] leds(bit o, bit z, bit f, bit p);
        return {4'h0, o, z, f, p};
    endfunction

    task automatic push(int cyc, logic [7:0] mask, logic [7:0] val, string name);
        exp_t e;
        e.cyc = cyc; e.mask = mask; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        nreset = 1'b0; comp_data_hi = 1'b0; comp_data_lo = 1'b0; mode = 2'd0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int c = 0;
        exp_t e;
        @(posedge clk); #1;
        comp_data_hi = 1'b1; mode = 2'd0; nreset = 1'b0;
        #1;
        checks++;
        if (obs_now() !== {4'd0, 4'b0010}) begin
            errors++; $display("FAIL reset_async: got %h expected %h", obs_now(), {4'd0, 4'b0010});
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (obs_now() !== {4'd0, 4'b0010}) begin
            errors++; $display("FAIL reset_held: got %h expected %h", obs_now(), {4'd0, 4'b0010});
        end
        comp_data_hi = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;
        sb.delete();
        push(1, 8'hFF, {4'd12, 4'b0010}, "reset_dac12");
        push(5, 8'hFF, {4'd12, 4'b0010}, "reset_idle");
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL reset_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_high();
        int c = 0;
        exp_t e;
        do_reset();
        sb.delete();
        push(2,       8'h0F, leds(0, 0, 1, 0),    "high_e2");
        push(3,       8'h0F, leds(1, 0, 0, 0),    "high_e3");
        push(4,       8'h0F, leds(1, 0, 0, 1),    "high_e4");
        push(500,     8'h0F, leds(1, 0, 0, 1),    "high_hold");
        push(3 + S,   8'h01, 8'h01,               "high_pulse_last");
        push(4 + S,   8'h01, {7'h0, PMEM},        "high_pulse_end");
        push(501 + S, 8'h0F, leds(1, 0, 0, PMEM), "high_stretch_last");
        push(502 + S, 8'h0F, leds(0, 0, 1, PMEM), "high_stretch_end");
        comp_data_hi = 1'b1;
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
            if (c == 500) comp_data_hi = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL high_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_handover();
        int c = 0;
        exp_t e;
        do_reset();
        sb.delete();
        push(502,      8'h0F, leds(1, 0, 0, 1),    "ho_before_zero");
        push(503,      8'h0F, leds(1, 1, 0, 1),    "ho_overlap");
        push(4 + S,    8'h01, 8'h01,               "ho_retrigger");
        push(502 + S,  8'h0F, leds(0, 1, 0, 1),    "ho_one_end");
        push(503 + S,  8'h01, 8'h01,               "ho_pulse_last");
        push(504 + S,  8'h01, {7'h0, PMEM},        "ho_pulse_end");
        push(1001 + S, 8'h0F, leds(0, 1, 0, PMEM), "ho_zero_last");
        push(1002 + S, 8'h0F, leds(0, 0, 1, PMEM), "ho_floating");
        comp_data_hi = 1'b1;
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
            if (c == 500) begin comp_data_hi = 1'b0; comp_data_lo = 1'b1; end
            if (c == 1000) comp_data_lo = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL ho_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_modes();
        int c = 0;
        exp_t e;
        do_reset();
        sb.delete();
        push(10, 8'hFF, {4'd12, 4'b1001}, "mode0");
        push(11, 8'hFF, {4'd8,  4'b1001}, "mode1");
        push(12, 8'hFF, {4'd6,  4'b1001}, "mode2");
        push(13, 8'hFF, {4'd4,  4'b1001}, "mode3");
        comp_data_hi = 1'b1;
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
            if (c == 10) mode = 2'd1;
            if (c == 11) mode = 2'd2;
            if (c == 12) mode = 2'd3;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL modes_timeout: got %0d pending expected 0", sb.size()); end
        // Reset in the middle of a running stretch must clear everything at once.
        nreset = 1'b0;
        #1;
        checks++;
        if (obs_now() !== {4'd0, 4'b0010}) begin
            errors++; $display("FAIL reset_abort: got %h expected %h", obs_now(), {4'd0, 4'b0010});
        end
    endtask

    task automatic test_invalid();
        int c = 0;
        exp_t e;
        do_reset();
        sb.delete();
        push(3,  8'h0F, leds(0, 0, 1, 0), "inv_e3");
        push(4,  8'h0F, leds(0, 0, 1, 1), "inv_pulse");
        push(60, 8'h0F, leds(0, 0, 1, 1), "inv_hold");
        comp_data_hi = 1'b1; comp_data_lo = 1'b1;
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL inv_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_glitch();
        int c = 0;
        exp_t e;
        do_reset();
        sb.delete();
        push(3,     8'h0F, leds(1, 0, 0, 0),    "gl_capture");
        push(4,     8'h0F, leds(1, 0, 0, 1),    "gl_pulse");
        push(2 + S, 8'h0F, leds(1, 0, 0, 1),    "gl_one_last");
        push(3 + S, 8'h0F, leds(0, 0, 1, 1),    "gl_one_end");
        push(4 + S, 8'hFF, {4'd12, 3'b001, PMEM}, "gl_pulse_end");
        comp_data_hi = 1'b1;
        while (sb.size() != 0 && c < LIMIT) begin
            @(posedge clk); #1; c++;
            while (sb.size() != 0 && sb[0].cyc == c) begin
                e = sb.pop_front(); checks++;
                if ((obs_now() & e.mask) !== e.val) begin
                    errors++; $display("FAIL %s cyc %0d: got %h expected %h", e.name, c, obs_now() & e.mask, e.val);
                end
            end
            if (c == 1) comp_data_hi = 1'b0;
        end
        if (sb.size() != 0) begin checks++; errors++; $display("FAIL gl_timeout: got %0d pending expected 0", sb.size()); end
    endtask

    initial begin
        test_reset();
        test_high();
        test_handover();
        test_modes();
        test_invalid();
        test_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/logic_probe1.md
Name: logic_probe1

Overview:
- Digital logic-probe core.
- Two external window comparators tell it whether the probed node is above the high threshold (`comp_data_hi`) or below the low threshold (`comp_data_lo`).
- The block sets the comparator reference through a 4-bit DAC code selected by `mode`, classifies the node as one, zero or floating, and detects transitions.
- It drives four indicator LEDs, with level and pulse indications stretched so short events are visible to the eye.

Parameters:
- `COUNTER_WIDTH`, default 20: width of the stretch counters. Stretch length is 2^`COUNTER_WIDTH`-1 clock cycles.

Ports:
- `clk`  in  1  system clock; all state is on the rising edge.
- `nreset`  in  1  asynchronous active-low reset.
- `comp_data_hi`  in  1  comparator output, 1 = node above high threshold; asynchronous to `clk`.
- `comp_data_lo`  in  1  comparator output, 1 = node below low threshold; asynchronous to `clk`.
- `mode`  in  2  logic-family select.
- `dac_value`  out  4  threshold reference code to the DAC.
- `led_one`  out  1  node high (stretched).
- `led_zero`  out  1  node low (stretched).
- `led_floating`  out  1  node neither high nor low.
- `led_pulse`  out  1  transition detected (stretched).

Behaviour:
- **Reset:** one clock `clk`; reset `nreset` is asynchronous and active-low.
  - While `nreset` is low: all synchronizers, counters and registered outputs clear.
  - Output values in reset: `dac_value`=0, `led_one`=0, `led_zero`=0, `led_pulse`=0, `led_floating`=1.
  - Reset asserted mid-stretch aborts the stretch immediately.
- **DAC code:** `dac_value` is registered from `mode`, 1-cycle latency.
  - Mapping: `mode` 0→12 (5V TTL), 1→8 (3.3V), 2→6 (2.5V), 3→4 (1.8V).
  - A `mode` change does not clear the LEDs.
- **Synchronizers:** `comp_data_hi` and `comp_data_lo` each pass through a 2-flop synchronizer, giving `hi_s` and `lo_s`.
- **Classification (combinational on synced values):**
  - `lvl_one` = `hi_s` & !`lo_s`.
  - `lvl_zero` = `lo_s` & !`hi_s`.
  - `hi_s`=`lo_s`=1 is physically invalid and is treated as neither.
- **One stretch counter** (`COUNTER_WIDTH` bits):
  - While `lvl_one`, load all-ones.
  - Otherwise, decrement if nonzero; saturate at 0.
  - `led_one` = (counter != 0), registered.
- **Zero stretch counter:** identical to the one counter, driven by `lvl_zero`; drives `led_zero`.
- **Level latency:** `led_one` or `led_zero` asserts on the 3rd rising edge after a stable comparator input rises. It deasserts 2^W-1 cycles after the synced level drops.
- **Floating:** `led_floating` = !`led_one` & !`led_zero`.
- **Overlap:** `led_one` and `led_zero` may both be 1 (for example a stretch still running after a hi→lo change). `led_floating` is then 0.
- **Pulse detect:** event = rising edge of `hi_s` OR rising edge of `lo_s` (1-cycle delayed copies kept internally).
  - The event loads the pulse counter with all-ones. The counter decrements otherwise and saturates at 0.
  - `led_pulse` = (pulse counter != 0), registered; it asserts one cycle after the `lvl` LED.
  - Retrigger during a stretch reloads the counter to full length.
  - Simultaneous hi and lo edges count as one event.
- **Counter wrap:** counters never wrap; they saturate at 0.

Optional Feature:
- Macro: `LOGIC_PROBE_PULSE_MEMORY_EN`.
- Defined: once a pulse event occurs, `led_pulse` latches at 1 until `nreset`. The pulse counter is still present but does not affect the LED.
- Undefined: stretched behaviour as above.

Test Plan:
- **Reset:** hold `nreset`=0 with `comp_data_hi`=1 → `led_floating`=1, all other LEDs 0, `dac_value`=0. Release with `mode`=0 → `dac_value`=12 after 1 cycle.
- **High level** (W=16): `comp_data_hi`=1 for 500 cycles → `led_one`=1 on the 3rd edge and `led_pulse`=1 on the 4th. After release, `led_one` stays 1 for 65535 more cycles, then 0, and `led_floating` returns to 1.
- **Hi→lo handover:** `comp_data_hi` 1→0 then `comp_data_lo`=1 for 500 cycles → `led_zero`=1 while `led_one` is still stretched, `led_floating`=0, `led_pulse` retriggered. All LEDs clear to floating about 65535 cycles after `lo` drops.
- **Modes:** `mode`=1,2,3 → `dac_value`=8,6,4, each one cycle later. LED state is unaffected.
- **Invalid input:** `comp_data_hi`=`comp_data_lo`=1 from idle → `led_one`=`led_zero`=0, `led_floating`=1, `led_pulse`=1 (edge event).
- **Short glitch:** a 1-cycle `comp_data_hi` pulse is either captured, giving `led_one`=1 and `led_pulse`=1 for 65535 cycles, or missed entirely; no X outputs. With `LOGIC_PROBE_PULSE_MEMORY_EN` defined, `led_pulse` stays 1 until reset.
